// File: rtl/matrix_mult_mnp.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_mult_mnp
//  Brief    : Sequential signed matrix multiplier C[MxP] = A[MxN] * B[NxP].
//             A and B are loaded through write ports while idle. Each C element
//             takes N multiply-accumulate cycles and is then presented on a
//             valid/ready output port in row-major order.
//             Optional feature macro MATMUL_SAT_EN: saturate results to the
//             signed DATA_WIDTH range and raise a sticky ovf flag; when the
//             macro is undefined, results wrap and ovf is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_mult_mnp #(
   parameter int M          = 3,
   parameter int N          = 3,
   parameter int P          = 3,
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic signed [DATA_WIDTH-1:0]           a_in,
   input  logic [((M*N > 1) ? $clog2(M*N) : 1)-1:0] a_addr,
   input  logic                                   a_wen,
   input  logic signed [DATA_WIDTH-1:0]           b_in,
   input  logic [((N*P > 1) ? $clog2(N*P) : 1)-1:0] b_addr,
   input  logic                                   b_wen,
   output logic signed [DATA_WIDTH-1:0]           c_out,
   output logic                                   c_valid,
   input  logic                                   c_ready,
   output logic [((M > 1) ? $clog2(M) : 1)-1:0]   c_row,
   output logic [((P > 1) ? $clog2(P) : 1)-1:0]   c_col,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   ovf
);

   localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(N);
   localparam int A_DEPTH   = M*N;
   localparam int B_DEPTH   = N*P;
   localparam int A_AW      = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
   localparam int B_AW      = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
   localparam int ROW_W     = (M > 1) ? $clog2(M) : 1;
   localparam int COL_W     = (P > 1) ? $clog2(P) : 1;
   localparam int K_W       = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Operand storage; deliberately not reset so contents survive rst
   logic signed [DATA_WIDTH-1:0] r_a_mem [A_DEPTH];
   logic signed [DATA_WIDTH-1:0] r_b_mem [B_DEPTH];

   logic [ROW_W-1:0]             r_row_idx;
   logic [COL_W-1:0]             r_col_idx;
   logic [K_W-1:0]               r_k;
   logic signed [ACC_WIDTH-1:0]  r_acc;
   logic signed [DATA_WIDTH-1:0] r_c_out;
   logic                         r_c_valid;
   logic [ROW_W-1:0]             r_c_row;
   logic [COL_W-1:0]             r_c_col;

   logic [A_AW-1:0]              w_a_idx;
   logic [B_AW-1:0]              w_b_idx;
   logic signed [DATA_WIDTH-1:0] w_a_val;
   logic signed [DATA_WIDTH-1:0] w_b_val;
   logic signed [2*DATA_WIDTH-1:0] w_prod;
   logic signed [ACC_WIDTH-1:0]  w_acc_base;
   logic signed [ACC_WIDTH-1:0]  w_sum;
   logic signed [DATA_WIDTH-1:0] w_res;
   logic                         w_k_last;
   logic                         w_col_last;
   logic                         w_row_last;

   assign w_k_last   = (r_k == K_W'(N-1));
   assign w_col_last = (r_col_idx == COL_W'(P-1));
   assign w_row_last = (r_row_idx == ROW_W'(M-1));

   // Row-major operand addressing: A[i][k] and B[k][j]
   assign w_a_idx = A_AW'(r_row_idx) * A_AW'(N) + A_AW'(r_k);
   assign w_b_idx = B_AW'(r_k) * B_AW'(P) + B_AW'(r_col_idx);
   assign w_a_val = r_a_mem[w_a_idx];
   assign w_b_val = r_b_mem[w_b_idx];

   // Full-precision signed product; the first MAC of an element ignores the
   // previous accumulator so each element starts from zero
   assign w_prod     = (2*DATA_WIDTH)'(w_a_val) * (2*DATA_WIDTH)'(w_b_val);
   assign w_acc_base = (r_k == '0) ? '0 : r_acc;
   assign w_sum      = w_acc_base + ACC_WIDTH'(w_prod);

`ifdef MATMUL_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      (ACC_WIDTH'(1) <<< (DATA_WIDTH-1)) - ACC_WIDTH'(1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      -(ACC_WIDTH'(1) <<< (DATA_WIDTH-1));

   logic signed [ACC_WIDTH-1:0] w_shift;
   logic                        w_clamp_hi;
   logic                        w_clamp_lo;
   logic                        r_ovf;

   assign w_shift    = w_sum >>> FRAC_BITS;
   assign w_clamp_hi = (w_shift > SAT_MAX);
   assign w_clamp_lo = (w_shift < SAT_MIN);
   assign w_res      = w_clamp_hi ? SAT_MAX[DATA_WIDTH-1:0] :
                       w_clamp_lo ? SAT_MIN[DATA_WIDTH-1:0] :
                                    w_shift[DATA_WIDTH-1:0];
   assign ovf        = r_ovf;

   // Sticky clamp flag, cleared when a new job is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_MAC && w_k_last && (w_clamp_hi || w_clamp_lo)) begin
         r_ovf <= 1'b1;
      end
   end
`else
   assign w_res = DATA_WIDTH'(w_sum >>> FRAC_BITS);
   assign ovf   = 1'b0;
`endif

   // Operand writes are accepted only while idle and only in range
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE) begin
         if (a_wen && (32'(a_addr) < A_DEPTH)) begin
            r_a_mem[a_addr] <= a_in;
         end
         if (b_wen && (32'(b_addr) < B_DEPTH)) begin
            r_b_mem[b_addr] <= b_in;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)    w_state_nxt = S_MAC;
         S_MAC:   if (w_k_last) w_state_nxt = S_OUT;
         S_OUT:   if (c_ready)  w_state_nxt = (w_row_last && w_col_last) ? S_DONE : S_MAC;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Counters, accumulator and the held output element
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_idx <= '0;
         r_col_idx <= '0;
         r_k       <= '0;
         r_acc     <= '0;
         r_c_out   <= '0;
         r_c_valid <= 1'b0;
         r_c_row   <= '0;
         r_c_col   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_row_idx <= '0;
                  r_col_idx <= '0;
                  r_k       <= '0;
                  r_acc     <= '0;
               end
            end
            S_MAC: begin
               r_acc <= w_sum;
               if (w_k_last) begin
                  r_k       <= '0;
                  r_c_out   <= w_res;
                  r_c_valid <= 1'b1;
                  r_c_row   <= r_row_idx;
                  r_c_col   <= r_col_idx;
               end else begin
                  r_k <= r_k + K_W'(1);
               end
            end
            S_OUT: begin
               if (c_ready) begin
                  r_c_valid <= 1'b0;
                  if (w_col_last) begin
                     r_col_idx <= '0;
                     if (!w_row_last) begin
                        r_row_idx <= r_row_idx + ROW_W'(1);
                     end
                  end else begin
                     r_col_idx <= r_col_idx + COL_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign c_out   = r_c_out;
   assign c_valid = r_c_valid;
   assign c_row   = r_c_row;
   assign c_col   = r_c_col;
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_mnp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_mult_mnp
//  Brief    : Directed self-checking bench for matrix_mult_mnp. Instance u0 uses
//             default 3x3x3 parameters, instance u1 uses M=2, N=3, P=2.
//             Expected overflow behaviour follows MATMUL_SAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_mult_mnp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic        start0 = 0, a_wen0 = 0, b_wen0 = 0, c_ready0 = 1;
   logic [31:0] a_in0 = 0, b_in0 = 0;
   logic [3:0]  a_addr0 = 0, b_addr0 = 0;
   logic [31:0] c_out0;
   logic        c_valid0, busy0, done0, ovf0;
   logic [1:0]  c_row0, c_col0;

   // 2x3x2 instance
   logic        start1 = 0, a_wen1 = 0, b_wen1 = 0, c_ready1 = 1;
   logic [31:0] a_in1 = 0, b_in1 = 0;
   logic [2:0]  a_addr1 = 0, b_addr1 = 0;
   logic [31:0] c_out1;
   logic        c_valid1, busy1, done1, ovf1;
   logic [0:0]  c_row1, c_col1;

   matrix_mult_mnp u0 (
      .clk(clk), .rst(rst), .start(start0),
      .a_in(a_in0), .a_addr(a_addr0), .a_wen(a_wen0),
      .b_in(b_in0), .b_addr(b_addr0), .b_wen(b_wen0),
      .c_out(c_out0), .c_valid(c_valid0), .c_ready(c_ready0),
      .c_row(c_row0), .c_col(c_col0),
      .busy(busy0), .done(done0), .ovf(ovf0)
   );

   matrix_mult_mnp #(.M(2), .N(3), .P(2)) u1 (
      .clk(clk), .rst(rst), .start(start1),
      .a_in(a_in1), .a_addr(a_addr1), .a_wen(a_wen1),
      .b_in(b_in1), .b_addr(b_addr1), .b_wen(b_wen1),
      .c_out(c_out1), .c_valid(c_valid1), .c_ready(c_ready1),
      .c_row(c_row1), .c_col(c_col1),
      .busy(busy1), .done(done1), .ovf(ovf1)
   );

   int total = 0;
   int bad   = 0;

   // Observations gathered by run_job0
   int          got_n, job_len, done_cnt, stall_seen, timed_out;
   logic        busy_after;
   logic [31:0] got_val [16];
   logic [31:0] got_row [16];
   logic [31:0] got_col [16];
   logic [31:0] stall_val [8];
   logic [31:0] stall_row [8];
   logic [31:0] stall_col [8];

   task automatic wr_a0(input int addr, input logic [31:0] v);
      @(posedge clk); #1;
      a_wen0 = 1; a_addr0 = 4'(addr); a_in0 = v;
      @(posedge clk); #1;
      a_wen0 = 0;
   endtask

   task automatic wr_b0(input int addr, input logic [31:0] v);
      @(posedge clk); #1;
      b_wen0 = 1; b_addr0 = 4'(addr); b_in0 = v;
      @(posedge clk); #1;
      b_wen0 = 0;
   endtask

   task automatic load_ident0();
      for (int i = 0; i < 9; i++) begin
         wr_a0(i, (i % 4 == 0) ? 32'd1 : 32'd0);
         wr_b0(i, 32'(i + 1));
      end
   endtask

   // Runs one job on u0; optionally stalls one element and injects a
   // write+start pulse at a given cycle after start was sampled
   task automatic run_job0(input int stall_elem, input int stall_n, input int inject_cyc);
      @(posedge clk); #1;
      start0 = 1; c_ready0 = 1;
      got_n = 0; done_cnt = 0; stall_seen = 0; job_len = 0;
      busy_after = 1'bx; timed_out = 1;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(posedge clk); #1;
         start0 = 0; a_wen0 = 0;
         if (cyc == inject_cyc) begin
            start0 = 1; a_wen0 = 1; a_addr0 = 4'd0; a_in0 = 32'd100;
         end
         if (job_len != 0) begin
            busy_after = busy0;
            timed_out  = 0;
            break;
         end
         if (done0) begin
            done_cnt++;
            job_len = cyc;
         end
         if (c_valid0) begin
            if (got_n == stall_elem && stall_seen < stall_n) begin
               c_ready0 = 0;
               stall_val[stall_seen] = c_out0;
               stall_row[stall_seen] = 32'(c_row0);
               stall_col[stall_seen] = 32'(c_col0);
               stall_seen++;
            end else begin
               c_ready0 = 1;
               if (got_n < 16) begin
                  got_val[got_n] = c_out0;
                  got_row[got_n] = 32'(c_row0);
                  got_col[got_n] = 32'(c_col0);
               end
               got_n++;
            end
         end else begin
            c_ready0 = 1;
         end
      end
      start0 = 0; a_wen0 = 0; c_ready0 = 1;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (c_out0 !== 32'd0)   begin bad++; $display("FAIL reset_c_out act=%h req=0", c_out0); end
      total++; if (c_valid0 !== 1'b0)  begin bad++; $display("FAIL reset_c_valid act=%b req=0", c_valid0); end
      total++; if (c_row0 !== 2'd0 || c_col0 !== 2'd0) begin bad++; $display("FAIL reset_rowcol act=%0d,%0d req=0,0", c_row0, c_col0); end
      total++; if (busy0 !== 1'b0 || done0 !== 1'b0 || ovf0 !== 1'b0) begin bad++; $display("FAIL reset_flags act=%b%b%b req=000", busy0, done0, ovf0); end
      total++; if (c_valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL reset_u1 act=%b%b%b req=000", c_valid1, busy1, done1); end
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_identity();
      run_job0(-1, 0, -1);
      total++; if (timed_out != 0) begin bad++; $display("FAIL ident_timeout act=%0d req=0", timed_out); end
      total++; if (got_n != 9) begin bad++; $display("FAIL ident_count act=%0d req=9", got_n); end
      for (int e = 0; e < 9 && e < got_n; e++) begin
         total++;
         if (got_val[e] !== 32'(e + 1) || got_row[e] !== 32'(e / 3) || got_col[e] !== 32'(e % 3)) begin
            bad++;
            $display("FAIL ident_elem%0d act=%0d@(%0d,%0d) req=%0d@(%0d,%0d)", e, got_val[e], got_row[e], got_col[e], e + 1, e / 3, e % 3);
         end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL ident_done act=%0d req=1", done_cnt); end
      total++; if (job_len != 37) begin bad++; $display("FAIL ident_len act=%0d req=37", job_len); end
      total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL ident_busy_after_done act=%b req=0", busy_after); end
      total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL ident_ovf act=%b req=0", ovf0); end
   endtask

   task automatic test_backpressure();
      run_job0(4, 5, -1);
      total++; if (stall_seen != 5) begin bad++; $display("FAIL bp_stall_cycles act=%0d req=5", stall_seen); end
      for (int s = 0; s < 5 && s < stall_seen; s++) begin
         total++;
         if (stall_val[s] !== 32'd5 || stall_row[s] !== 32'd1 || stall_col[s] !== 32'd1) begin
            bad++;
            $display("FAIL bp_hold%0d act=%0d@(%0d,%0d) req=5@(1,1)", s, stall_val[s], stall_row[s], stall_col[s]);
         end
      end
      total++; if (got_n != 9) begin bad++; $display("FAIL bp_count act=%0d req=9", got_n); end
      total++; if (got_n > 4 && got_val[4] !== 32'd5) begin bad++; $display("FAIL bp_elem4 act=%0d req=5", got_val[4]); end
      total++; if (got_n > 8 && got_val[8] !== 32'd9) begin bad++; $display("FAIL bp_elem8 act=%0d req=9", got_val[8]); end
      total++; if (job_len != 42) begin bad++; $display("FAIL bp_len act=%0d req=42", job_len); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done act=%0d req=1", done_cnt); end
   endtask

   task automatic test_busy_ignore();
      run_job0(-1, 0, 10);
      total++; if (got_n != 9) begin bad++; $display("FAIL busy_count act=%0d req=9", got_n); end
      total++; if (job_len != 37) begin bad++; $display("FAIL busy_len act=%0d req=37", job_len); end
      for (int e = 0; e < 9 && e < got_n; e++) begin
         total++;
         if (got_val[e] !== 32'(e + 1)) begin bad++; $display("FAIL busy_elem%0d act=%0d req=%0d", e, got_val[e], e + 1); end
      end
      // A second job reveals whether A[0] was overwritten
      run_job0(-1, 0, -1);
      total++; if (got_n != 9 || got_val[0] !== 32'd1 || got_val[1] !== 32'd2 || got_val[2] !== 32'd3) begin
         bad++; $display("FAIL busy_a_kept act=%0d,%0d,%0d n=%0d req=1,2,3 n=9", got_val[0], got_val[1], got_val[2], got_n);
      end
   endtask

   task automatic test_reset_midjob();
      int  n;
      bool_found: begin end
      n = 0;
      @(posedge clk); #1;
      start0 = 1; c_ready0 = 1;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(posedge clk); #1;
         start0 = 0;
         if (c_valid0) n++;
         if (n == 3) break;
      end
      total++; if (n != 3) begin bad++; $display("FAIL rstmid_reach act=%0d req=3", n); end
      @(posedge clk); #1;          // now in MAC of element (1,0)
      total++; if (busy0 !== 1'b1 || c_out0 !== 32'd3) begin bad++; $display("FAIL rstmid_pre act=busy%b out%0d req=busy1 out3", busy0, c_out0); end
      rst = 1;
      #1;
      total++; if (c_out0 !== 32'd0 || c_valid0 !== 1'b0 || c_row0 !== 2'd0 || c_col0 !== 2'd0) begin
         bad++; $display("FAIL rstmid_outputs act=%h,%b,%0d,%0d req=0,0,0,0", c_out0, c_valid0, c_row0, c_col0);
      end
      total++; if (busy0 !== 1'b0 || done0 !== 1'b0 || ovf0 !== 1'b0) begin bad++; $display("FAIL rstmid_flags act=%b%b%b req=000", busy0, done0, ovf0); end
      @(posedge clk); #1;
      rst = 0;
      n = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(posedge clk); #1;
         if (done0 !== 1'b0 || busy0 !== 1'b0) n++;
      end
      total++; if (n != 0) begin bad++; $display("FAIL rstmid_no_done act=%0d req=0", n); end
      run_job0(-1, 0, -1);
      total++; if (got_n != 9 || done_cnt != 1) begin bad++; $display("FAIL rstmid_rerun act=n%0d d%0d req=n9 d1", got_n, done_cnt); end
      for (int e = 0; e < 9 && e < got_n; e++) begin
         total++;
         if (got_val[e] !== 32'(e + 1)) begin bad++; $display("FAIL rstmid_elem%0d act=%0d req=%0d", e, got_val[e], e + 1); end
      end
   endtask

   task automatic test_small();
      logic [31:0] av [6];
      logic [31:0] bv [6];
      logic [31:0] ev [4];
      logic [31:0] obs [4];
      int lat, n, dcnt;
      av = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
      bv = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
      ev = '{32'd58, 32'd64, 32'd139, 32'd154};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         a_wen1 = 1; a_addr1 = 3'(i); a_in1 = av[i];
         b_wen1 = 1; b_addr1 = 3'(i); b_in1 = bv[i];
      end
      @(posedge clk); #1;
      a_wen1 = 0; b_wen1 = 0;
      start1 = 1; c_ready1 = 1;
      lat = 0; n = 0; dcnt = 0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(posedge clk); #1;
         start1 = 0;
         if (c_valid1) begin
            if (lat == 0) lat = cyc;
            if (n < 4) begin
               obs[n] = c_out1;
               total++;
               if (c_row1 !== 1'(n / 2) || c_col1 !== 1'(n % 2)) begin
                  bad++; $display("FAIL small_idx%0d act=(%0d,%0d) req=(%0d,%0d)", n, c_row1, c_col1, n / 2, n % 2);
               end
            end
            n++;
         end
         if (done1) begin dcnt++; break; end
      end
      total++; if (lat != 4) begin bad++; $display("FAIL small_latency act=%0d req=4", lat); end
      total++; if (n != 4) begin bad++; $display("FAIL small_count act=%0d req=4", n); end
      total++; if (dcnt != 1) begin bad++; $display("FAIL small_done act=%0d req=1", dcnt); end
      for (int e = 0; e < 4 && e < n; e++) begin
         total++;
         if (obs[e] !== ev[e]) begin bad++; $display("FAIL small_elem%0d act=%0d req=%0d", e, obs[e], ev[e]); end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_val;
      logic        exp_ovf;
`ifdef MATMUL_SAT_EN
      exp_val = 32'h7FFF_FFFF; exp_ovf = 1'b1;
`else
      exp_val = 32'h0000_0003; exp_ovf = 1'b0;
`endif
      for (int i = 0; i < 9; i++) begin
         wr_a0(i, 32'h7FFF_FFFF);
         wr_b0(i, 32'h7FFF_FFFF);
      end
      run_job0(-1, 0, -1);
      total++; if (got_n != 9) begin bad++; $display("FAIL ovf_count act=%0d req=9", got_n); end
      for (int e = 0; e < 9 && e < got_n; e++) begin
         total++;
         if (got_val[e] !== exp_val) begin bad++; $display("FAIL ovf_elem%0d act=%h req=%h", e, got_val[e], exp_val); end
      end
      total++; if (ovf0 !== exp_ovf) begin bad++; $display("FAIL ovf_flag act=%b req=%b", ovf0, exp_ovf); end
   endtask

   initial begin
      test_reset();
      load_ident0();
      test_identity();
      test_backpressure();
      test_busy_ignore();
      test_reset_midjob();
      test_small();
      test_overflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
